// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - synchronize and debounce three active-low buttons into one-cycle strobes
// and one slide switch into a clean level.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic ar,
    input  logic A_Key,
    input  logic Rd_Key,
    input  logic Wr_Key,
    input  logic IT_Raw,
    output logic A_Pulse,
    output logic Rd_Pulse,
    output logic Wr_Pulse,
    output logic IT_Level,
    output logic Busy
);

    localparam logic [CNT_W-1:0] LP_BTN_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_SW_LAST  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LP_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    logic [2:0] w_btn_raw;
    logic [2:0] r_btn_s1;
    logic [2:0] r_btn_s2;
    logic [2:0] w_btn_pulse;
    logic [2:0] w_btn_active;
    logic       r_sw_s1;
    logic       r_sw_s2;
    logic [CNT_W-1:0] r_sw_cnt;
    logic       r_it_level;
    logic       r_busy;

    assign w_btn_raw = {Wr_Key, Rd_Key, A_Key};

    // Buttons idle high, so their synchronizers come out of reset as "released".
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            r_btn_s1 <= 3'b111;
            r_btn_s2 <= 3'b111;
            r_sw_s1  <= 1'b0;
            r_sw_s2  <= 1'b0;
        end else begin
            r_btn_s1 <= w_btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= IT_Raw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_btn
        btn_state_t       r_state;
        btn_state_t       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_pulse;
        logic             w_pulse_nxt;
        logic             w_sync;

        assign w_sync = r_btn_s2[g];

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_pulse_nxt = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_sync) begin
                        w_state_nxt = ST_PRESS_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (w_sync) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_cnt == LP_BTN_LAST) begin
                        w_state_nxt = ST_HELD;
                        w_pulse_nxt = 1'b1;
                    end else if (r_cnt != LP_CNT_MAX) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (w_sync) begin
                        w_state_nxt = ST_RELEASE_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!w_sync) begin
                        w_state_nxt = ST_HELD;
                    end else if (r_cnt == LP_BTN_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_cnt != LP_CNT_MAX) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge ar) begin
            if (!ar) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        assign w_btn_pulse[g]  = r_pulse;
        assign w_btn_active[g] = (r_state != ST_IDLE);
    end

    // The first disagreeing sample starts the count, so a level change needs
    // DEBOUNCE_CYCLES+1 agreeing samples, matching the button press latency.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            r_sw_cnt   <= '0;
            r_it_level <= 1'b0;
        end else if (r_sw_s2 == r_it_level) begin
            r_sw_cnt <= '0;
        end else if (r_sw_cnt == LP_SW_LAST) begin
            r_sw_cnt   <= '0;
            r_it_level <= r_sw_s2;
        end else if (r_sw_cnt != LP_CNT_MAX) begin
            r_sw_cnt <= r_sw_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= |w_btn_active;
        end
    end

    assign A_Pulse  = w_btn_pulse[0];
    assign Rd_Pulse = w_btn_pulse[1];
    assign Wr_Pulse = w_btn_pulse[2];
    assign IT_Level = r_it_level;
    assign Busy     = r_busy;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner with a run-length debounce model.
module tb_key_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic ar = 1'b0;
    logic A_Key = 1'b0;
    logic Rd_Key = 1'b0;
    logic Wr_Key = 1'b0;
    logic IT_Raw = 1'b1;
    logic A_Pulse, Rd_Pulse, Wr_Pulse, IT_Level, Busy;

    key_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk(clk), .ar(ar),
        .A_Key(A_Key), .Rd_Key(Rd_Key), .Wr_Key(Wr_Key), .IT_Raw(IT_Raw),
        .A_Pulse(A_Pulse), .Rd_Pulse(Rd_Pulse), .Wr_Pulse(Wr_Pulse),
        .IT_Level(IT_Level), .Busy(Busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    logic [4:0] exp_q[$];

    // Model: each channel holds an accepted level (buttons: 1 = pressed) and the
    // length of the current run of synchronized samples that disagree with it.
    bit m_s1[4], m_s2[4], m_lv[4], m_pulse[3], m_busy;
    int m_run[4];

    function automatic void m_reset();
        for (int c = 0; c < 4; c++) begin
            m_s1[c] = (c < 3);
            m_s2[c] = (c < 3);
            m_lv[c] = 1'b0;
            m_run[c] = 0;
            if (c < 3) m_pulse[c] = 1'b0;
        end
        m_busy = 1'b0;
    endfunction

    function automatic void m_step(input bit [3:0] raw);
        bit nb;
        bit lvl_in;
        nb = 1'b0;
        for (int c = 0; c < 3; c++) nb = nb | m_lv[c] | (m_run[c] > 0);
        m_busy = nb;
        for (int c = 0; c < 4; c++) begin
            lvl_in = (c < 3) ? !m_s2[c] : m_s2[c];
            if (c < 3) m_pulse[c] = 1'b0;
            if (lvl_in != m_lv[c]) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == D + 1) begin
                    m_lv[c] = lvl_in;
                    m_run[c] = 0;
                    if (c < 3 && lvl_in) m_pulse[c] = 1'b1;
                end
            end else begin
                m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = raw[c];
        end
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (!ar) m_reset();
            else m_step({IT_Raw, Wr_Key, Rd_Key, A_Key});
            @(negedge clk);
            if (!ar) m_reset();
            exp_q.push_back({m_pulse[0], m_pulse[1], m_pulse[2], m_lv[3], m_busy});
        end
    end

    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if ({A_Pulse, Rd_Pulse, Wr_Pulse, IT_Level, Busy} !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t act(A,Rd,Wr,IT,Busy)=%b exp=%b",
                             $time, {A_Pulse, Rd_Pulse, Wr_Pulse, IT_Level, Busy}, e);
                end
            end
        end
    end

    always @(posedge clk) edge_n++;

    int a_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    int a_edge = 0, rd_edge = 0, wr_edge = 0, it_edge = 0;
    logic it_prev = 1'b0;

    always @(negedge clk) begin
        if (A_Pulse)  begin a_cnt++;  a_edge  = edge_n; end
        if (Rd_Pulse) begin rd_cnt++; rd_edge = edge_n; end
        if (Wr_Pulse) begin wr_cnt++; wr_edge = edge_n; end
        if (IT_Level && !it_prev) it_edge = edge_n;
        it_prev = IT_Level;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    initial begin
        int low_e;
        int hold;
        tick(3);
        chk("reset_outs", int'({A_Pulse, Rd_Pulse, Wr_Pulse, IT_Level, Busy}), 0);
        A_Key = 1'b1; Rd_Key = 1'b1; Wr_Key = 1'b1; IT_Raw = 1'b0;
        tick(1);
        ar = 1'b1;
        tick(5);
        chk("post_reset_outs", int'({A_Pulse, Rd_Pulse, Wr_Pulse, IT_Level, Busy}), 0);

        a_cnt = 0;
        A_Key = 1'b0; low_e = edge_n + 1;
        tick(20);
        A_Key = 1'b1;
        tick(12);
        chk("clean_a_count", a_cnt, 1);
        chk("clean_a_latency", a_edge - low_e, 6);
        chk("clean_busy_idle", int'(Busy), 0);

        rd_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            Rd_Key = 1'b0; tick(2);
            Rd_Key = 1'b1; tick(2);
        end
        Rd_Key = 1'b0; low_e = edge_n + 1;
        tick(15);
        Rd_Key = 1'b1; tick(1);
        Rd_Key = 1'b0; tick(1);
        Rd_Key = 1'b1; tick(1);
        Rd_Key = 1'b0; tick(5);
        Rd_Key = 1'b1; tick(12);
        chk("bounce_rd_count", rd_cnt, 1);
        chk("bounce_rd_latency", rd_edge - low_e, 6);

        wr_cnt = 0;
        Wr_Key = 1'b0; tick(200);
        Wr_Key = 1'b1; tick(12);
        chk("long_wr_count", wr_cnt, 1);

        a_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        A_Key = 1'b0; Wr_Key = 1'b0; tick(12);
        A_Key = 1'b1; Wr_Key = 1'b1; tick(12);
        chk("simul_a_count", a_cnt, 1);
        chk("simul_wr_count", wr_cnt, 1);
        chk("simul_same_edge", a_edge - wr_edge, 0);
        chk("simul_rd_quiet", rd_cnt, 0);

        IT_Raw = 1'b1; tick(3);
        IT_Raw = 1'b0; tick(10);
        chk("sw_glitch", int'(IT_Level), 0);
        IT_Raw = 1'b1; low_e = edge_n + 1;
        tick(10);
        chk("sw_level", int'(IT_Level), 1);
        chk("sw_latency", it_edge - low_e, 6);

        A_Key = 1'b0; tick(10);
        ar = 1'b0; #1;
        chk("rst_mid_outs", int'({A_Pulse, IT_Level, Busy}), 0);
        tick(2);
        ar = 1'b1; a_cnt = 0; low_e = edge_n + 1;
        tick(12);
        chk("rst_held_count", a_cnt, 1);
        chk("rst_held_latency", a_edge - low_e, 6);
        A_Key = 1'b1; tick(12);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(39) == 0) begin
                ar = 1'b0; tick(2); ar = 1'b1;
            end
            A_Key  = ($urandom_range(2) != 0);
            Rd_Key = ($urandom_range(2) != 0);
            Wr_Key = ($urandom_range(2) != 0);
            IT_Raw = $urandom_range(1);
            hold = $urandom_range(12, 1);
            tick(hold);
        end
        A_Key = 1'b1; Rd_Key = 1'b1; Wr_Key = 1'b1;
        tick(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
